// File: rtl/serial_arith_pkg.sv
// Shared constants for the bit-serial arithmetic units: state encodings and default width.
package serial_arith_pkg;

  localparam int DEF_WIDTH = 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = IDLE,
    S_RUN  = RUN,
    S_DONE = DONE
  } state_t;

endpackage

// File: rtl/fs_bit.sv
// Combinational one-bit full subtractor: d = a - b - bin, bout set when it underflows.
module fs_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: Diff = A - B - Bin, one bit per clock LSB first, start/done handshake.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Borrow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state, nxt;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [WIDTH-2:0] res;
  logic             bf;
  logic [CW-1:0]    cnt;
  logic             d, bo, last;

  fs_bit u_fs (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (bf),
    .d    (d),
    .bout (bo)
  );

  assign last  = (cnt == CW'(WIDTH - 1));
  assign ready = (state == S_IDLE);
  assign done  = (state == S_DONE);

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (start) nxt = S_RUN;
      S_RUN:   if (last)  nxt = S_DONE;
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  // Result bits enter at the top; only WIDTH-1 are held since the last bit goes straight to Diff.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res    <= '0;
      bf     <= 1'b0;
      cnt    <= '0;
      Diff   <= '0;
      Borrow <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          a_sr <= A;
          b_sr <= B;
          bf   <= Bin;
          cnt  <= '0;
        end
        S_RUN: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          res  <= (WIDTH-1)'({d, res} >> 1);
          bf   <= bo;
          cnt  <= cnt + 1'b1;
          if (last) begin
            Diff   <= {d, res};
            Borrow <= bo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboarded bench: directed WIDTH=8 vectors plus an exhaustive WIDTH=2 sweep.
module tb_serial_subtractor;

  typedef struct {
    logic [7:0] d;
    logic       b;
    int         acc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start8 = 1'b0, bin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       ready8, done8, borrow8;
  logic [7:0] diff8;
  logic       start2 = 1'b0, bin2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0;
  logic       ready2, done2, borrow2;
  logic [1:0] diff2;

  int   ncmp = 0, nfail = 0, cyc = 0;
  exp_t q8[$];
  exp_t q2[$];

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8), .Bin(bin8),
    .ready(ready8), .done(done8), .Diff(diff8), .Borrow(borrow8)
  );

  serial_subtractor #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .A(a2), .B(b2), .Bin(bin2),
    .ready(ready2), .done(done2), .Diff(diff2), .Borrow(borrow2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    ncmp++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitors: pop an expectation on every done pulse and check value and latency.
  always @(negedge clk) begin
    if (rst_n && done8) begin
      if (q8.size() == 0) chk("done8_unexpected", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q8.pop_front();
        chk("diff8", {23'd0, borrow8, diff8}, {23'd0, e.b, e.d});
        chk("lat8", cyc - e.acc, 32'd8);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done2) begin
      if (q2.size() == 0) chk("done2_unexpected", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q2.pop_front();
        chk("diff2", {29'd0, borrow2, diff2}, {29'd0, e.b, e.d[1:0]});
        chk("lat2", cyc - e.acc, 32'd2);
      end
    end
  end

  // Issue one op on dut8 and wait for it to return to IDLE; ready is checked low while busy.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                     input logic [7:0] ed, input logic eb);
    exp_t e;
    bit   back;
    @(negedge clk);
    chk("ready8_before", ready8, 1'b1);
    a8 = a; b8 = b; bin8 = bi; start8 = 1'b1;
    e.d = ed; e.b = eb; e.acc = cyc + 1;
    q8.push_back(e);
    @(negedge clk);
    start8 = 1'b0; a8 = ~a; b8 = ~b; bin8 = ~bi;
    chk("ready8_busy", ready8, 1'b0);
    back = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ready8) begin back = 1; break; end
    end
    chk("op8_timeout", back, 1'b1);
  endtask

  initial begin
    exp_t e;
    bit   ok;
    #12;
    chk("rst_ready", ready8, 1'b1);
    chk("rst_done", done8, 1'b0);
    chk("rst_diff", diff8, 8'h00);
    chk("rst_borrow", borrow8, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_ready", ready8, 1'b1);
    chk("post_rst_diff", {borrow8, diff8}, 9'h000);

    op8(8'h5A, 8'h23, 1'b0, 8'h37, 1'b0);
    op8(8'h10, 8'h20, 1'b0, 8'hF0, 1'b1);
    op8(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1);
    op8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

    // Busy rejection: second start lands while RUN and must be ignored.
    @(negedge clk);
    a8 = 8'h09; b8 = 8'h04; bin8 = 1'b0; start8 = 1'b1;
    e.d = 8'h05; e.b = 1'b0; e.acc = cyc + 1;
    q8.push_back(e);
    @(negedge clk); start8 = 1'b0;
    @(negedge clk); a8 = 8'hFF; b8 = 8'h00; start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;
    repeat (20) @(negedge clk);
    chk("busy_queue_empty", q8.size(), 32'd0);
    chk("busy_diff", {borrow8, diff8}, 9'h005);

    // Mid-op reset after 3 RUN edges: immediate clear, no done.
    @(negedge clk);
    a8 = 8'h33; b8 = 8'h11; bin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1 start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_ready", ready8, 1'b1);
    chk("abort_done", done8, 1'b0);
    chk("abort_diff", {borrow8, diff8}, 9'h000);
    @(negedge clk); rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_no_done", q8.size(), 32'd0);
    op8(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0);

    // WIDTH=2 sweep with start held high: one op per IDLE visit.
    start2 = 1'b1;
    for (int v = 0; v < 32; v++) begin
      logic [2:0] r;
      ok = 0;
      for (int i = 0; i < 10; i++) begin
        if (ready2) begin ok = 1; break; end
        @(negedge clk);
      end
      chk("sweep_timeout", ok, 1'b1);
      a2 = v[4:3]; b2 = v[2:1]; bin2 = v[0];
      r = ({1'b0, a2} - {1'b0, b2} - {2'b00, bin2});
      e.d = {6'd0, r[1:0]}; e.b = r[2]; e.acc = cyc + 1;
      q2.push_back(e);
      @(negedge clk);
    end
    start2 = 1'b0;
    repeat (10) @(negedge clk);
    chk("sweep_queue_empty", q2.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
